// File: rtl/lif_array_scheduler.sv
// Time-multiplexed first-order LIF update over N virtual neurons.
// One neuron is updated per clock during a sweep; spikes are published with a done pulse.
module lif_array_scheduler #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int BETA_SHIFT = 1,
    parameter int THRESHOLD  = 100,
    parameter int RESET_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cur_wr_en,
    input  logic [$clog2(N)-1:0] cur_addr,
    input  logic [WIDTH-1:0]     cur_data,
    output logic                 cur_ready,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spike_vec,
    input  logic [$clog2(N)-1:0] mon_addr,
    output logic [WIDTH-1:0]     mon_state
);
    localparam int AW = $clog2(N);
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] TH_S  = SW'(THRESHOLD);
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0]     TH_W  = WIDTH'(THRESHOLD);
    localparam logic [AW-1:0]        LAST  = AW'(N - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [WIDTH-1:0]  r_u   [N];
    logic [WIDTH-1:0]  r_cur [N];
    logic [N-1:0]      r_refr;
    logic [N-1:0]      r_spk_new;
    logic [N-1:0]      r_spike_vec;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;
    logic [WIDTH-1:0]  r_mon;

    logic [WIDTH-1:0]     w_u;
    logic [WIDTH-1:0]     w_i;
    logic                 w_r;
    logic [WIDTH-1:0]     w_decay;
    logic signed [SW-1:0] w_sum;
    logic [WIDTH-1:0]     w_clamped;
    logic                 w_fire;
    logic [N-1:0]         w_spk_next;
    logic                 w_wr_ok;

    always_comb begin
        w_u     = r_u[r_idx];
        w_i     = r_cur[r_idx];
        w_r     = r_refr[r_idx];
        w_decay = w_u - (w_u >> BETA_SHIFT);
        w_sum   = $signed({2'b00, w_decay}) + $signed({2'b00, w_i});
        if (w_r) begin
            w_sum = (RESET_ZERO != 0) ? '0 : w_sum - TH_S;
        end
        // Saturate the signed intermediate back into the unsigned state range.
        if (w_sum < 0) begin
            w_clamped = '0;
        end else if (w_sum > MAX_S) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_sum[WIDTH-1:0];
        end
        w_fire            = (w_clamped > TH_W);
        w_spk_next        = r_spk_new;
        w_spk_next[r_idx] = w_fire;
        w_wr_ok           = cur_wr_en && (int'(cur_addr) < N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_refr      <= '0;
            r_spk_new   <= '0;
            r_spike_vec <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_mon       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_u[i]   <= '0;
                r_cur[i] <= '0;
            end
        end else begin
            r_mon  <= (int'(mon_addr) < N) ? r_u[mon_addr] : '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ok) begin
                        r_cur[cur_addr] <= cur_data;
                    end
                    if (start) begin
                        r_state   <= ST_SWEEP;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_spk_new <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_u[r_idx]    <= w_clamped;
                    r_refr[r_idx] <= w_fire;
                    r_spk_new     <= w_spk_next;
                    if (r_idx == LAST) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_spike_vec <= w_spk_next;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cur_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign spike_vec = r_spike_vec;
    assign mon_state = r_mon;
endmodule

// File: tb/tb_lif_array_scheduler.sv
// Scoreboard bench for lif_array_scheduler: subtract-mode and reset-to-zero instances.
module tb_lif_array_scheduler;
    logic       clk;
    logic       rst_n;
    logic       cur_wr_en;
    logic [1:0] cur_addr;
    logic [7:0] cur_data;
    logic       start0, start1;
    logic [1:0] mon_addr;
    logic       ready0, ready1, busy0, busy1, done0, done1;
    logic [3:0] spk0, spk1;
    logic [7:0] ms0, ms1;

    typedef struct {
        int         kind;   // 0: sweep dut0, 1: sweep dut1, 2: state probe of dut0
        logic [3:0] spk;
        logic [31:0] u;     // {U3,U2,U1,U0}
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   probe_req = 0;
    int   probe_ack = 0;
    bit   mon_busy = 0;

    lif_array_scheduler #(.N(4), .WIDTH(8), .BETA_SHIFT(1), .THRESHOLD(100), .RESET_ZERO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cur_wr_en(cur_wr_en), .cur_addr(cur_addr), .cur_data(cur_data),
        .cur_ready(ready0), .start(start0), .busy(busy0), .done(done0), .spike_vec(spk0),
        .mon_addr(mon_addr), .mon_state(ms0)
    );

    lif_array_scheduler #(.N(4), .WIDTH(8), .BETA_SHIFT(1), .THRESHOLD(100), .RESET_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cur_wr_en(cur_wr_en), .cur_addr(cur_addr), .cur_data(cur_data),
        .cur_ready(ready1), .start(start1), .busy(busy1), .done(done1), .spike_vec(spk1),
        .mon_addr(mon_addr), .mon_state(ms1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every done pulse or probe request, then reads back U[0..3].
    initial begin
        exp_t it;
        int   src;
        forever begin
            @(negedge clk);
            if (done0 || done1 || (probe_req != probe_ack)) begin
                mon_busy = 1;
                src = done0 ? 0 : (done1 ? 1 : 2);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got source %0d, expected none", src);
                end else begin
                    it = q.pop_front();
                    chk("event_source", src, it.kind);
                    chk("spike_vec", (it.kind == 1) ? spk1 : spk0, it.spk);
                    for (int k = 0; k < 4; k++) begin
                        mon_addr = 2'(k);
                        @(negedge clk);
                        chk($sformatf("U[%0d]", k), (it.kind == 1) ? ms1 : ms0, it.u[k*8 +: 8]);
                    end
                    if (it.kind == 2) probe_ack++;
                end
                mon_busy = 0;
            end
        end
    end

    task automatic push(input int kind, input logic [3:0] spk, input logic [31:0] u);
        exp_t e;
        e.kind = kind;
        e.spk  = spk;
        e.u    = u;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !mon_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", 32'(q.size()), 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cur_wr_en = 1'b1;
        cur_addr  = a;
        cur_data  = d;
        @(negedge clk);
        cur_wr_en = 1'b0;
    endtask

    task automatic wr_all(input logic [7:0] d);
        for (int i = 0; i < 4; i++) wr(2'(i), d);
    endtask

    task automatic sweep(input int kind, input logic [3:0] spk, input logic [31:0] u);
        push(kind, spk, u);
        if (kind == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_idle();
    endtask

    task automatic probe(input logic [3:0] spk, input logic [31:0] u);
        push(2, spk, u);
        probe_req++;
        wait_idle();
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_spk0", spk0, 0);
        chk("rst_mon0", ms0, 0);
        chk("rst_ready0", ready0, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_spk1", spk1, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; cur_wr_en = 1'b0; cur_addr = '0; cur_data = '0;
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        probe(4'b0000, 32'h0);

        // Single step with latency check: busy 4 cycles, done on the 5th
        wr_all(8'd50);
        push(0, 4'b0000, {8'd50, 8'd50, 8'd50, 8'd50});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lat_busy_c%0d", k), busy0, 1);
            chk($sformatf("lat_done_c%0d", k), done0, 0);
            @(negedge clk);
        end
        chk("lat_done_c5", done0, 1);
        chk("lat_busy_c5", busy0, 0);
        wait_idle();
        chk("ready_after_done", ready0, 1);

        // Distinct currents; last write shares the cycle with start; U=100 is not a spike
        do_reset();
        wr(2'd0, 8'd10);
        wr(2'd1, 8'd150);
        wr(2'd2, 8'd100);
        push(0, 4'b1010, {8'd101, 8'd100, 8'd150, 8'd10});
        cur_wr_en = 1'b1; cur_addr = 2'd3; cur_data = 8'd101; start0 = 1'b1;
        @(negedge clk);
        cur_wr_en = 1'b0; start0 = 1'b0;
        wait_idle();

        // Accumulate / subtract with busy-time write and start ignored
        do_reset();
        wr_all(8'd80);
        sweep(0, 4'b0000, {8'd80, 8'd80, 8'd80, 8'd80});
        push(0, 4'b1111, {8'd120, 8'd120, 8'd120, 8'd120});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        cur_wr_en = 1'b1; cur_addr = 2'd0; cur_data = 8'd200; start0 = 1'b1;
        chk("busy_ready_low", ready0, 0);
        chk("busy_high", busy0, 1);
        @(negedge clk);
        cur_wr_en = 1'b0; start0 = 1'b0;
        wait_idle();
        chk("no_restart_busy", busy0, 0);
        sweep(0, 4'b0000, {8'd40, 8'd40, 8'd40, 8'd40});
        sweep(0, 4'b0000, {8'd100, 8'd100, 8'd100, 8'd100});
        sweep(0, 4'b1111, {8'd130, 8'd130, 8'd130, 8'd130});

        // Reset at idx=2 aborts the sweep with no done pulse
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_mon", ms0, 130);
        chk("pre_abort_spk", spk0, 4'b1111);
        do_reset();
        repeat (8) @(negedge clk);
        probe(4'b0000, 32'h0);

        // Underflow: refractory subtract below zero clamps to 0
        do_reset();
        wr_all(8'd80);
        sweep(0, 4'b0000, {8'd80, 8'd80, 8'd80, 8'd80});
        sweep(0, 4'b1111, {8'd120, 8'd120, 8'd120, 8'd120});
        wr_all(8'd0);
        sweep(0, 4'b0000, 32'h0);

        // Saturation at 255
        do_reset();
        wr_all(8'd255);
        sweep(0, 4'b1111, {8'd255, 8'd255, 8'd255, 8'd255});
        sweep(0, 4'b1111, {8'd255, 8'd255, 8'd255, 8'd255});
        wr_all(8'd0);
        sweep(0, 4'b0000, {8'd28, 8'd28, 8'd28, 8'd28});

        // Reset-to-zero instance
        do_reset();
        wr_all(8'd80);
        sweep(1, 4'b0000, {8'd80, 8'd80, 8'd80, 8'd80});
        sweep(1, 4'b1111, {8'd120, 8'd120, 8'd120, 8'd120});
        sweep(1, 4'b0000, 32'h0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
